// File: rtl/sm3_pad_pkg.sv
// SM3 padder shared definitions.
// Block geometry, FSM states and keep-mask helper.
package sm3_pad_pkg;

  localparam int SM3_BLK_BYTES = 64;
  localparam int SM3_LEN_BYTES = 8;

  typedef enum logic {
    S_DATA,
    S_TAIL
  } state_e;

  function automatic logic [4:0] popcount_keep(
    input logic [15:0] keep
  );
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(keep[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/sm3_pad_beat_fmt.sv
// Composes one padded beat from message data and stream position.
// Purely combinational; shared by data and tail phases.
module sm3_pad_beat_fmt
  import sm3_pad_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data_i,
  input  logic [60:0]   lf_i,
  input  logic [60:0]   pos_i,
  input  logic          fin_i,
  output logic [DW-1:0] beat_o
);

  localparam int DWB = DW / 8;
  localparam logic [5:0] LEN_OFF =
    6'(SM3_BLK_BYTES - SM3_LEN_BYTES);

  logic [63:0] len_bits;

  assign len_bits = {lf_i, 3'b000};

  function automatic logic [7:0] fmt_byte(
    input logic [7:0]  d,
    input logic [60:0] p,
    input logic [60:0] lf,
    input logic        fin,
    input logic [63:0] len
  );
    logic [5:0] off;
    off = p[5:0];
    if (p < lf) return d;
    if (p == lf) return 8'h80;
    if (fin && off >= LEN_OFF) begin
      return len[8*(7-int'(off[2:0])) +: 8];
    end
    return 8'h00;
  endfunction

  always_comb begin
    beat_o = '0;
    for (int k = 0; k < DWB; k++) begin
      beat_o[DW-1-8*k -: 8] = fmt_byte(
        data_i[DW-1-8*k -: 8],
        pos_i + 61'(k),
        lf_i,
        fin_i,
        len_bits
      );
    end
  end

endmodule

// File: rtl/sm3_pad_stream.sv
// Streaming SM3 message padder, DW-bit beats in and out.
// Single output register stage with full valid/ready backpressure.
module sm3_pad_stream
  import sm3_pad_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            msg_vld_i,
  output logic            msg_rdy_o,
  input  logic [DW-1:0]   msg_d_i,
  input  logic [DW/8-1:0] msg_keep_i,
  input  logic            msg_lst_i,
  output logic            pad_vld_o,
  input  logic            pad_rdy_i,
  output logic [DW-1:0]   pad_d_o,
  output logic            pad_blk_lst_o,
  output logic            pad_msg_lst_o
);

  localparam int DWB = DW / 8;
  localparam int BPB = SM3_BLK_BYTES / DWB;
  localparam int BW  = $clog2(BPB);
  localparam logic [BW-1:0] B_LAST = BW'(BPB - 1);

  state_e        state_q, state_d;
  logic [60:0]   l_q, l_d;
  logic [60:0]   lf_q, lf_d;
  logic [BW-1:0] b_q, b_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] d_q, d_d;
  logic          blk_q, blk_d;
  logic          mlst_q, mlst_d;

  logic          adv;
  logic          in_fire;
  logic [4:0]    n;
  logic [60:0]   lf_new;
  logic [60:0]   fmt_lf;
  logic [DW-1:0] fmt_data;
  logic [DW-1:0] fmt_beat;
  logic [54:0]   fin_blk;
  logic          fin;
  logic          blk_end;

  assign adv     = ~vld_q | pad_rdy_i;
  assign msg_rdy_o = rst_n & (state_q == S_DATA) & adv;
  assign in_fire = msg_vld_i & msg_rdy_o;

  assign n      = popcount_keep(16'(msg_keep_i));
  assign lf_new = l_q + 61'(n);
  assign fmt_lf = (state_q == S_DATA) ? lf_new : lf_q;
  assign fmt_data = (state_q == S_DATA) ? msg_d_i : '0;

  // Length field needs 8 bytes; offset >= 56 pushes it one block on.
  assign fin_blk = fmt_lf[60:6] + 55'(fmt_lf[5:3] == 3'b111);
  assign fin     = (l_q[60:6] == fin_blk);
  assign blk_end = (b_q == B_LAST);

  sm3_pad_beat_fmt #(
    .DW(DW)
  ) u_fmt (
    .data_i (fmt_data),
    .lf_i   (fmt_lf),
    .pos_i  (l_q),
    .fin_i  (fin),
    .beat_o (fmt_beat)
  );

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    lf_d    = lf_q;
    b_d     = b_q;
    vld_d   = vld_q;
    d_d     = d_q;
    blk_d   = blk_q;
    mlst_d  = mlst_q;
    if (adv) begin
      vld_d = 1'b0;
      unique case (state_q)
        S_DATA: begin
          if (in_fire) begin
            vld_d = 1'b1;
            blk_d = blk_end;
            l_d   = l_q + 61'(DWB);
            b_d   = b_q + BW'(1);
            if (!msg_lst_i) begin
              d_d    = msg_d_i;
              mlst_d = 1'b0;
            end else begin
              d_d    = fmt_beat;
              lf_d   = lf_new;
              mlst_d = blk_end & fin;
              if (blk_end & fin) begin
                l_d = '0;
                b_d = '0;
              end else begin
                state_d = S_TAIL;
              end
            end
          end
        end
        S_TAIL: begin
          vld_d  = 1'b1;
          d_d    = fmt_beat;
          blk_d  = blk_end;
          mlst_d = blk_end & fin;
          l_d    = l_q + 61'(DWB);
          b_d    = b_q + BW'(1);
          if (blk_end & fin) begin
            state_d = S_DATA;
            l_d     = '0;
            b_d     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DATA;
      l_q     <= '0;
      lf_q    <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      d_q     <= '0;
      blk_q   <= 1'b0;
      mlst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      lf_q    <= lf_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      d_q     <= d_d;
      blk_q   <= blk_d;
      mlst_q  <= mlst_d;
    end
  end

  assign pad_vld_o     = vld_q;
  assign pad_d_o       = d_q;
  assign pad_blk_lst_o = blk_q;
  assign pad_msg_lst_o = mlst_q;

endmodule

// File: tb/tb_sm3_pad_stream.sv
// Bench for sm3_pad_stream at DW 32/64/128.
// Directed SM3 vectors plus randomized backpressure against a byte model.
module tb_sm3_pad_stream;

  typedef logic [129:0] beat_t;

  logic         clk;
  logic         rst_n;
  logic         msg_vld;
  logic [127:0] msg_d;
  logic [15:0]  msg_keep;
  logic         msg_lst;
  logic         pad_rdy;
  logic [1:0]   sel;

  logic         o_rdy [3];
  logic         o_vld [3];
  logic [127:0] o_d   [3];
  logic         o_bl  [3];
  logic         o_ml  [3];

  logic         s_rdy, s_vld, s_bl, s_ml;
  logic [127:0] s_d;

  int n_chk;
  int n_err;

  logic [7:0] msg [$];
  beat_t      got [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = 32 << g;
    logic         rdy, vld, bl, ml;
    logic [W-1:0] d;
    sm3_pad_stream #(
      .DW(W)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .msg_vld_i     (msg_vld && (sel == 2'(g))),
      .msg_rdy_o     (rdy),
      .msg_d_i       (msg_d[W-1:0]),
      .msg_keep_i    (msg_keep[W/8-1:0]),
      .msg_lst_i     (msg_lst),
      .pad_vld_o     (vld),
      .pad_rdy_i     (pad_rdy && (sel == 2'(g))),
      .pad_d_o       (d),
      .pad_blk_lst_o (bl),
      .pad_msg_lst_o (ml)
    );
    assign o_rdy[g] = rdy;
    assign o_vld[g] = vld;
    assign o_d[g]   = 128'(d);
    assign o_bl[g]  = bl;
    assign o_ml[g]  = ml;
  end

  assign s_rdy = o_rdy[sel];
  assign s_vld = o_vld[sel];
  assign s_d   = o_d[sel];
  assign s_bl  = o_bl[sel];
  assign s_ml  = o_ml[sel];

  task automatic check(
    input string        tag,
    input logic [159:0] act,
    input logic [159:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_seq(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'(i));
  endtask

  task automatic drive_beat(input int j, input int dwb, input int nb);
    int lf;
    int n;
    lf = msg.size();
    msg_d = '0;
    for (int k = 0; k < dwb; k++) begin
      int p;
      p = j * dwb + k;
      msg_d[(dwb-1-k)*8 +: 8] = (p < lf) ? msg[p] : 8'hEE;
    end
    msg_lst = (j == nb - 1);
    if (j == nb - 1) begin
      n = lf - j * dwb;
      msg_keep = 16'(((1 << n) - 1) << (dwb - n));
    end else begin
      msg_keep = 16'($urandom);
    end
  endtask

  // Reference: whole padded byte string, then cut into beats.
  task automatic build_exp(input int dwb, output beat_t exp [$]);
    int lf, t;
    logic [63:0]  lb;
    logic [7:0]   pb [$];
    logic [127:0] d;
    lf = msg.size();
    t  = ((lf + 8) / 64 + 1) * 64;
    lb = 64'(longint'(lf) * 8);
    exp.delete();
    for (int p = 0; p < t; p++) begin
      if (p < lf) pb.push_back(msg[p]);
      else if (p == lf) pb.push_back(8'h80);
      else if (p >= t - 8) pb.push_back(lb[8*(t-1-p) +: 8]);
      else pb.push_back(8'h00);
    end
    for (int b = 0; b < t / dwb; b++) begin
      d = '0;
      for (int k = 0; k < dwb; k++) begin
        d[(dwb-1-k)*8 +: 8] = pb[b*dwb+k];
      end
      exp.push_back({(b == t/dwb - 1),
                     (((b + 1) * dwb) % 64 == 0), d});
    end
  endtask

  task automatic run_msg(
    input int    w,
    input int    gap,
    input int    duty,
    input string tag
  );
    int    dwb, nb, j, cyc, bad, first, idx;
    logic  in_fire, hold;
    beat_t cur, held;
    beat_t exp [$];
    dwb = w / 8;
    sel = (w == 32) ? 2'd0 : (w == 64) ? 2'd1 : 2'd2;
    build_exp(dwb, exp);
    got.delete();
    nb = (msg.size() == 0) ? 1 : (msg.size() + dwb - 1) / dwb;
    j = 0; cyc = 0; bad = 0; hold = 1'b0; held = '0;
    drive_beat(j, dwb, nb);
    msg_vld = ($urandom_range(99) >= gap);
    pad_rdy = ($urandom_range(99) < duty);
    while ((j < nb || got.size() < exp.size()) && cyc < 4000) begin
      @(negedge clk);
      in_fire = msg_vld && s_rdy;
      if (s_vld) begin
        cur = {s_ml, s_bl, s_d};
        if (hold && cur != held) bad++;
        if (pad_rdy) begin
          got.push_back(cur);
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = cur;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (in_fire) j++;
      if (in_fire || !msg_vld) begin
        drive_beat(j, dwb, nb);
        msg_vld = (j < nb) && ($urandom_range(99) >= gap);
      end
      pad_rdy = ($urandom_range(99) < duty);
    end
    msg_vld = 1'b0;
    pad_rdy = 1'b0;
    check($sformatf("%s_nbeats", tag), got.size(), exp.size());
    check($sformatf("%s_stall", tag), bad, 0);
    first = -1;
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      if (got[i] != exp[i] && first < 0) first = i;
    end
    idx = (first < 0) ? 0 : first;
    if (idx < got.size()) begin
      check($sformatf("%s_beat%0d", tag, idx), got[idx], exp[idx]);
    end
  endtask

  int cnt;
  int w, len;

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; msg_vld = 1'b0; msg_d = '0;
    msg_keep = '0; msg_lst = 1'b0; pad_rdy = 1'b0; sel = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", s_vld, 0);
    check("rst_d", s_d, 0);
    check("rst_flags", {s_bl, s_ml}, 0);
    check("rst_rdy", s_rdy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", s_rdy, 1);
    @(posedge clk);
    #1;

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(32, 0, 100, "abc");
    check("abc_b0", got[0], {2'b00, 128'h61626380});
    check("abc_b14", got[14], {2'b00, 128'h0});
    check("abc_b15", got[15], {2'b11, 128'h18});

    set_seq(0);
    run_msg(32, 0, 100, "empty");
    check("empty_b0", got[0], {2'b00, 128'h80000000});
    check("empty_b15", got[15], {2'b11, 128'h0});

    set_seq(56);
    run_msg(32, 0, 100, "m56");
    check("m56_b0", got[0], {2'b00, 128'h00010203});
    check("m56_b14", got[14], {2'b00, 128'h80000000});
    check("m56_b15", got[15], {2'b01, 128'h0});
    check("m56_b30", got[30], {2'b00, 128'h0});
    check("m56_b31", got[31], {2'b11, 128'h1C0});

    set_seq(64);
    run_msg(64, 0, 100, "m64");
    check("m64_b7", got[7], {2'b01, 128'h38393A3B3C3D3E3F});
    check("m64_b8", got[8], {2'b00, 128'h8000000000000000});
    check("m64_b15", got[15], {2'b11, 128'h200});

    set_seq(53);
    run_msg(128, 0, 100, "m53");
    check("m53_b3", got[3],
          {2'b11, 128'h3031323334800000_00000000000001A8});

    // Reset while the tail is still being generated.
    sel = 2'd0; pad_rdy = 1'b1;
    msg_d = 128'h61626300; msg_keep = 16'h000E;
    msg_lst = 1'b1; msg_vld = 1'b1;
    @(negedge clk);
    check("tail_acc_rdy", s_rdy, 1);
    @(posedge clk);
    #1 msg_vld = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("tail_rdy_low", s_rdy, 0);
    check("tail_vld", s_vld, 1);
    rst_n = 1'b0;
    #2;
    check("midrst_vld", s_vld, 0);
    check("midrst_d", s_d, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (s_vld) cnt++;
    end
    check("no_beat_after_rst", cnt, 0);
    @(posedge clk);
    #1 pad_rdy = 1'b0;

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(32, 0, 100, "post_rst");

    for (int m = 0; m < 200; m++) begin
      w   = 32 << $urandom_range(2);
      len = $urandom_range(150);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg(w, 30, 30, $sformatf("rnd%0d", m));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sm3_pad_stream.md
# sm3_pad_stream

Parametrised SM3 message padder, successor to the fixed-width 32/64-bit padding core. It accepts a byte-granular message stream of width DW and emits the SM3-padded stream of the same width, 512-bit block aligned, to the compression engine: message bytes, then 0x80, then zeros, then the 64-bit big-endian bit length. Both sides use full valid/ready handshakes with backpressure. Zero-length messages and every residue of message length mod 64 are supported.

## Interface
- DW, 32, beat width in bits; legal values 32, 64, 128. Derived values:
  - DWB = DW/8, bytes per beat.
  - BPB = 64/DWB, beats per 512-bit block.
- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- msg_vld_i  in  1  input beat valid
- msg_rdy_o  out  1  input beat accepted when msg_vld_i && msg_rdy_o
- msg_d_i  in  DW  message bytes, big-endian: byte 0 is in [DW-1:DW-8]
- msg_keep_i  in  DWB  valid-byte mask, sampled on the last beat only
- msg_lst_i  in  1  last beat of the message
- pad_vld_o  out  1  output beat valid
- pad_rdy_i  in  1  output beat consumed when pad_vld_o && pad_rdy_i
- pad_d_o  out  DW  padded beat
- pad_blk_lst_o  out  1  beat is the final beat of a 512-bit block
- pad_msg_lst_o  out  1  beat is the final beat of the padded message

## Operation
- States: S_DATA, S_TAIL.
- Byte counter L: 61 bits. Beat index B within the block: log2(BPB) bits.
- S_DATA, non-last accepted beat: forwarded unchanged. L += DWB; keep is ignored.
- S_DATA, last accepted beat: n = popcount(msg_keep_i), 0..DWB. The mask is required to be MSB-contiguous; a non-contiguous mask is treated by count only. Final length Lf = L + n is latched.
- Every emitted beat is built per byte at stream position p = (block_base + B*DWB + k):
  - p < Lf: message byte.
  - p == Lf: 0x80.
  - Byte offset 56..63 of the final block: length field, {Lf,3'b0} big-endian.
  - Otherwise: 0x00.
- Final block is the block containing position Lf + 8. An extra block is therefore needed exactly when Lf mod 64 >= 56.
- After the last beat is accepted, if that beat did not also complete the final block, go to S_TAIL. In S_TAIL, generate beats without input until the final block's last beat is emitted, then return to S_DATA with L = 0 and B = 0.
- Partial last beat: 0x80 merges into the same beat. Full last beat (n == DWB): 0x80 opens the next beat.
- DW=128: the final beat may carry message bytes, 0x80 and the length field together.
- pad_blk_lst_o = (B == BPB-1). pad_msg_lst_o = pad_blk_lst_o of the final block.
- msg_rdy_o = (state == S_DATA) && (~pad_vld_o || pad_rdy_i). It is low throughout S_TAIL.
- Length arithmetic is modulo 2^64 bits; overflow is not flagged.
- Reset: all registers clear. Reset mid-message or mid-tail discards all state. No partial block is emitted after reset.

## Timing
- The output is a single register stage. An input beat accepted at edge t appears on pad_d_o after edge t.
- Sustained throughput is 1 beat/clk in both states when pad_rdy_i = 1.
- Output stall: while pad_vld_o && ~pad_rdy_i, pad_d_o, pad_blk_lst_o and pad_msg_lst_o hold stable.
- Reset values: pad_vld_o=0, pad_d_o=0, pad_blk_lst_o=0, pad_msg_lst_o=0, msg_rdy_o=0 during reset. msg_rdy_o=1 on the first cycle after reset release.
- Back-to-back messages: the first beat of message N+1 may be accepted in the same cycle the final beat of message N is consumed.

## Structure
- Package sm3_pad_pkg holds:
  - Constants SM3_BLK_BYTES=64, SM3_LEN_BYTES=8.
  - The state enum.
  - Function popcount_keep.
- Sub-module sm3_pad_beat_fmt is purely combinational: inputs are data, Lf, beat position and final-block flag; output is the composed beat. It is shared by S_DATA and S_TAIL.
- Top level holds the FSM, the L and B counters, and the output register.

## Test plan
- DW=32, "abc": one beat 0x61626300, keep 4'b1110, lst.
  - Expect 16 beats: 0x61626380, then 14× 0x00000000, then 0x00000018.
  - blk_lst and msg_lst set on beat 16 only.
- DW=32, empty message: lst with keep 0.
  - Expect 0x80000000, 14× zero, then 0x00000000.
  - 16 beats total.
- DW=32, 56-byte message (14 full beats).
  - Expect beat 15 = 0x80000000 and 32 beats total.
  - blk_lst set on beats 16 and 32; msg_lst on beat 32 only.
  - Beat 31 = 0x0, beat 32 = 0x000001C0.
- DW=64, 64-byte message (8 full beats).
  - Expect 0x8000000000000000, 6 zero beats, then 0x0000000000000200.
  - 16 beats total.
- DW=128, 53-byte message: the final beat holds message bytes 48..52, then 0x80, then zeros, then length 0x1A8 in its low 64 bits.
- Random pad_rdy_i at 30 % duty plus random msg_vld_i gaps across 200 messages. The output stream must match the reference model, with stable data during stalls. Assert rst_n mid-tail: no beat is emitted after release until new input arrives.
